// File: rtl/histo_link_pkg.sv
// Word layout and frame constants for the camera histogram serial link,
// shared by the transmitter and receiver sides.
package histo_link_pkg;

    localparam int HISTO_WORD_W   = 32;
    localparam int HISTO_SPACER_W = 8;
    localparam int HISTO_COUNT_W  = 24;
    localparam int HISTO_NUM_BINS = 1024;
    localparam int HISTO_SUM_W    = 34;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/histo_sclk_sync.sv
// Brings sclk/mosi into the clk domain through equal-depth synchronisers and
// flags the cycle on which the synchronised sclk rises.
module histo_sclk_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk_i,
    input  logic mosi_i,
    output logic rise,
    output logic data
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    // mosi has the same depth as sclk, so data is aligned with rise.
    assign rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign data = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/histo_stream_rx.sv
// Histogram stream receiver: deserialises {spacer, count} words, writes each
// bin count out, and reports frame id, frame sum and sticky protocol errors.
module histo_stream_rx
    import histo_link_pkg::*;
#(
    parameter int NUM_BINS     = HISTO_NUM_BINS,
    parameter int IDLE_TIMEOUT = 256,
    parameter int SYNC_STAGES  = 2,
    localparam int ADDR_W      = $clog2(NUM_BINS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sclk_i,
    input  logic                     mosi_i,
    input  logic                     enable,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [HISTO_COUNT_W-1:0] wr_data,
    output logic                     frame_done,
    output logic [HISTO_SPACER_W-1:0] frame_id,
    output logic [HISTO_SUM_W-1:0]   frame_sum,
    output logic                     err_spacer,
    output logic                     err_trunc,
    output logic                     err_seq,
    input  logic                     err_clr
);

    localparam int                IDLE_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_BINS - 1);

    logic rise, bit_in;

    histo_sclk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .sclk_i (sclk_i),
        .mosi_i (mosi_i),
        .rise   (rise),
        .data   (bit_in)
    );

    rx_state_e                  state_q, state_d;
    logic [HISTO_WORD_W-1:0]    shreg_q, shreg_d;
    logic [5:0]                 bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]          word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0]          idle_cnt_q, idle_cnt_d;
    logic [HISTO_SUM_W-1:0]     acc_q, acc_d;
    logic [HISTO_SPACER_W-1:0]  pend_id_q, pend_id_d;
    logic                       prev_valid_q, prev_valid_d;
    logic                       wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic [HISTO_COUNT_W-1:0]   wr_data_q, wr_data_d;
    logic                       frame_done_q, frame_done_d;
    logic [HISTO_SPACER_W-1:0]  frame_id_q, frame_id_d;
    logic [HISTO_SUM_W-1:0]     frame_sum_q, frame_sum_d;
    logic                       err_spacer_q, err_spacer_d;
    logic                       err_trunc_q, err_trunc_d;
    logic                       err_seq_q, err_seq_d;

    logic [HISTO_WORD_W-1:0]    word_next;
    logic [HISTO_SPACER_W-1:0]  spacer_next;
    logic [HISTO_SUM_W-1:0]     acc_sum;
    logic [HISTO_SPACER_W-1:0]  id_new;
    logic                       set_spacer, set_trunc, set_seq;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        acc_d        = acc_q;
        pend_id_d    = pend_id_q;
        prev_valid_d = prev_valid_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        frame_id_d   = frame_id_q;
        frame_sum_d  = frame_sum_q;
        set_spacer   = 1'b0;
        set_trunc    = 1'b0;
        set_seq      = 1'b0;

        word_next   = {shreg_q[HISTO_WORD_W-2:0], bit_in};
        spacer_next = word_next[HISTO_WORD_W-1:HISTO_COUNT_W];
        acc_sum     = acc_q + HISTO_SUM_W'(word_next[HISTO_COUNT_W-1:0]);
        id_new      = (word_cnt_q == '0) ? spacer_next : pend_id_q;

        if (rise) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IDLE_LIM) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && rise) begin
                    state_d    = ST_RECV;
                    shreg_d    = word_next;
                    bit_cnt_d  = 6'd1;
                    word_cnt_d = '0;
                    acc_d      = '0;
                end
            end
            ST_RECV: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (rise) begin
                    shreg_d = word_next;
                    if (bit_cnt_q == 6'd31) begin
                        bit_cnt_d  = 6'd0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q;
                        wr_data_d  = word_next[HISTO_COUNT_W-1:0];
                        acc_d      = acc_sum;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == '0) begin
                            pend_id_d = spacer_next;
                        end else if (spacer_next != '0) begin
                            set_spacer = 1'b1;
                        end
                        // Last bin: publish the frame on the same cycle as its write.
                        if (word_cnt_q == LAST_WORD) begin
                            frame_done_d = 1'b1;
                            frame_id_d   = id_new;
                            frame_sum_d  = acc_sum;
                            set_seq      = prev_valid_q && (id_new != frame_id_q + 8'd1);
                            prev_valid_d = 1'b1;
                            word_cnt_d   = '0;
                            state_d      = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else if (idle_cnt_d == IDLE_LIM) begin
                    set_trunc = 1'b1;
                    bit_cnt_d = 6'd0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_spacer_d = err_clr ? 1'b0 : (err_spacer_q | set_spacer);
        err_trunc_d  = err_clr ? 1'b0 : (err_trunc_q  | set_trunc);
        err_seq_d    = err_clr ? 1'b0 : (err_seq_q    | set_seq);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            acc_q        <= '0;
            pend_id_q    <= '0;
            prev_valid_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            frame_id_q   <= '0;
            frame_sum_q  <= '0;
            err_spacer_q <= 1'b0;
            err_trunc_q  <= 1'b0;
            err_seq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            acc_q        <= acc_d;
            pend_id_q    <= pend_id_d;
            prev_valid_q <= prev_valid_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            frame_id_q   <= frame_id_d;
            frame_sum_q  <= frame_sum_d;
            err_spacer_q <= err_spacer_d;
            err_trunc_q  <= err_trunc_d;
            err_seq_q    <= err_seq_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_id   = frame_id_q;
    assign frame_sum  = frame_sum_q;
    assign err_spacer = err_spacer_q;
    assign err_trunc  = err_trunc_q;
    assign err_seq    = err_seq_q;

endmodule
